// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the mem-port round-robin arbiter.
//   owner_idx_t : requester index as stored in the owner FIFO and the rr pointer.
//                 It is sized for up to MEM_ARB_MAX_REQ requesters, so one package
//                 serves every arbiter instance whatever its NUM_REQ.
//   rr_select   : first asserted request scanning upward from ptr, wrapping at num_req.
package mem_arb_pkg;

   localparam int MEM_ARB_MAX_REQ = 32;
   localparam int OWNER_W         = 5;

   typedef logic [OWNER_W-1:0] owner_idx_t;

   function automatic owner_idx_t rr_select(input logic [MEM_ARB_MAX_REQ-1:0] req,
                                            input owner_idx_t                  ptr,
                                            input int                          num_req);
      owner_idx_t sel;
      int         idx;
      sel = '0;
      // Scan from the farthest offset down so the closest requester to ptr wins.
      for (int i = MEM_ARB_MAX_REQ - 1; i >= 0; i--) begin
         if (i < num_req) begin
            idx = (int'(ptr) + i) % num_req;
            if (req[idx[4:0]]) sel = owner_idx_t'(idx);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// Owner FIFO: in-order record of which requester issued each granted request.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset (empties the FIFO)
//   push, push_idx    enqueue the granted requester index (ignored when full)
//   pop               dequeue the head (ignored when empty)
//   head              owner of the oldest outstanding request
//   full, empty       occupancy flags
// Depth need not be a power of two; pointers wrap explicitly.
module mem_arb_owner_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       push,
   input  owner_idx_t push_idx,
   input  logic       pop,
   output owner_idx_t head,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   owner_idx_t       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr];

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr] <= push_idx;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one mem-protocol master (mem-to-AXI adapter)
// among NUM_REQ mem requesters. An owner FIFO routes in-order responses back
// to the issuing port.
// Ports:
//   clk_i, rst_i                               clock, synchronous active-high reset
//   s_mem_req/addr/we/wdata/be  [NUM_REQ]      requester request side
//   s_mem_gnt/valid/rdata/error [NUM_REQ]      requester grant / response side
//   m_mem_req/addr/we/wdata/be                 request to the adapter
//   m_mem_gnt/valid/rdata/error                grant / response from the adapter
// Build option: define MEM_ARB_FIXED_PRIO_EN to pin the rr pointer at 0
// (lowest index always wins); FIFO and response routing are unchanged.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int MEM_ADDR_WIDTH  = 32,
   parameter int MEM_DATA_WIDTH  = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_REQ-1:0]          s_mem_req,
   input  logic [MEM_ADDR_WIDTH-1:0]   s_mem_addr  [NUM_REQ],
   input  logic [NUM_REQ-1:0]          s_mem_we,
   input  logic [MEM_DATA_WIDTH-1:0]   s_mem_wdata [NUM_REQ],
   input  logic [MEM_DATA_WIDTH/8-1:0] s_mem_be    [NUM_REQ],
   output logic [NUM_REQ-1:0]          s_mem_gnt,
   output logic [NUM_REQ-1:0]          s_mem_valid,
   output logic [MEM_DATA_WIDTH-1:0]   s_mem_rdata [NUM_REQ],
   output logic [NUM_REQ-1:0]          s_mem_error,
   output logic                        m_mem_req,
   output logic [MEM_ADDR_WIDTH-1:0]   m_mem_addr,
   output logic                        m_mem_we,
   output logic [MEM_DATA_WIDTH-1:0]   m_mem_wdata,
   output logic [MEM_DATA_WIDTH/8-1:0] m_mem_be,
   input  logic                        m_mem_gnt,
   input  logic                        m_mem_valid,
   input  logic [MEM_DATA_WIDTH-1:0]   m_mem_rdata,
   input  logic                        m_mem_error
);

   logic [MEM_ARB_MAX_REQ-1:0] req_ext;
   owner_idx_t                 sel;
   owner_idx_t                 rr_ptr;
   owner_idx_t                 head;
   logic                       any_req;
   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       grant;
   logic                       rsp_ok;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = s_mem_req;
   end

   assign any_req = |s_mem_req;
   assign sel     = rr_select(req_ext, rr_ptr, NUM_REQ);

   // Full blocks the request even if a pop lands this cycle, so there is no
   // combinational path from m_mem_valid to m_mem_req.
   assign m_mem_req = any_req && !fifo_full && !rst_i;
   assign grant     = m_mem_req && m_mem_gnt;
   assign rsp_ok    = m_mem_valid && !fifo_empty && !rst_i;

   always_comb begin
      m_mem_addr  = '0;
      m_mem_we    = 1'b0;
      m_mem_wdata = '0;
      m_mem_be    = '0;
      if (any_req) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_idx_t'(i) == sel) begin
               m_mem_addr  = s_mem_addr[i];
               m_mem_we    = s_mem_we[i];
               m_mem_wdata = s_mem_wdata[i];
               m_mem_be    = s_mem_be[i];
            end
         end
      end
   end

   always_comb begin
      s_mem_gnt   = '0;
      s_mem_valid = '0;
      s_mem_error = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         s_mem_rdata[i] = m_mem_rdata;
         if (grant && owner_idx_t'(i) == sel) s_mem_gnt[i] = 1'b1;
         if (rsp_ok && owner_idx_t'(i) == head) begin
            s_mem_valid[i] = 1'b1;
            s_mem_error[i] = m_mem_error;
         end
      end
   end

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr <= '0;
      end else if (grant) begin
         rr_ptr <= (int'(sel) == NUM_REQ - 1) ? '0 : sel + owner_idx_t'(1);
      end
   end
`endif

   mem_arb_owner_fifo #(
      .DEPTH    (MAX_OUTSTANDING)
   ) u_owner_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .push     (grant),
      .push_idx (sel),
      .pop      (m_mem_valid),
      .head     (head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   // A response with nobody waiting for it means the adapter and the arbiter
   // disagree about outstanding requests; it is dropped either way.
   always_ff @(posedge clk_i) begin
      if (!rst_i) assert (!(m_mem_valid && fifo_empty));
   end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [1:0]  s_mem_req;
   logic [31:0] s_mem_addr  [2];
   logic [1:0]  s_mem_we;
   logic [31:0] s_mem_wdata [2];
   logic [3:0]  s_mem_be    [2];
   logic [1:0]  s_mem_gnt;
   logic [1:0]  s_mem_valid;
   logic [31:0] s_mem_rdata [2];
   logic [1:0]  s_mem_error;
   logic        m_mem_req;
   logic [31:0] m_mem_addr;
   logic        m_mem_we;
   logic [31:0] m_mem_wdata;
   logic [3:0]  m_mem_be;
   logic        m_mem_gnt;
   logic        m_mem_valid;
   logic [31:0] m_mem_rdata;
   logic        m_mem_error;

   always #5 clk = ~clk;

   mem_rr_arbiter #(
      .NUM_REQ         (2),
      .MEM_ADDR_WIDTH  (32),
      .MEM_DATA_WIDTH  (32),
      .MAX_OUTSTANDING (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .s_mem_req   (s_mem_req),
      .s_mem_addr  (s_mem_addr),
      .s_mem_we    (s_mem_we),
      .s_mem_wdata (s_mem_wdata),
      .s_mem_be    (s_mem_be),
      .s_mem_gnt   (s_mem_gnt),
      .s_mem_valid (s_mem_valid),
      .s_mem_rdata (s_mem_rdata),
      .s_mem_error (s_mem_error),
      .m_mem_req   (m_mem_req),
      .m_mem_addr  (m_mem_addr),
      .m_mem_we    (m_mem_we),
      .m_mem_wdata (m_mem_wdata),
      .m_mem_be    (m_mem_be),
      .m_mem_gnt   (m_mem_gnt),
      .m_mem_valid (m_mem_valid),
      .m_mem_rdata (m_mem_rdata),
      .m_mem_error (m_mem_error)
   );

   // One expected observation per stimulus cycle.
   typedef struct {
      logic [1:0]  req;
      logic        mreq;
      logic [1:0]  gnt;
      logic [1:0]  vld;
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   bit   done = 1'b0;
   int   checks = 0;
   int   errors = 0;

   // Monitor: pops and compares at each falling edge, away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      int   p;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         checks++;
         if (m_mem_req !== e.mreq) begin
            errors++;
            $display("FAIL m_mem_req: got %b want %b at %0t", m_mem_req, e.mreq, $time);
         end
         checks++;
         if (s_mem_gnt !== e.gnt) begin
            errors++;
            $display("FAIL s_mem_gnt: got %b want %b at %0t", s_mem_gnt, e.gnt, $time);
         end
         if (e.gnt != 2'b00) begin
            checks++;
            if (m_mem_addr !== e.addr || m_mem_we !== e.we || m_mem_wdata !== e.wdata || m_mem_be !== e.be) begin
               errors++;
               $display("FAIL m_mem_fields: got a=%h we=%b wd=%h be=%h want a=%h we=%b wd=%h be=%h at %0t",
                        m_mem_addr, m_mem_we, m_mem_wdata, m_mem_be, e.addr, e.we, e.wdata, e.be, $time);
            end
         end
         if (e.req == 2'b00) begin
            checks++;
            if (m_mem_addr !== 32'h0 || m_mem_we !== 1'b0 || m_mem_wdata !== 32'h0 || m_mem_be !== 4'h0) begin
               errors++;
               $display("FAIL m_mem_idle: got a=%h we=%b wd=%h be=%h want all 0 at %0t",
                        m_mem_addr, m_mem_we, m_mem_wdata, m_mem_be, $time);
            end
         end
         checks++;
         if (s_mem_valid !== e.vld || s_mem_error !== (e.err ? e.vld : 2'b00)) begin
            errors++;
            $display("FAIL s_mem_valid: got v=%b e=%b want v=%b e=%b at %0t",
                     s_mem_valid, s_mem_error, e.vld, (e.err ? e.vld : 2'b00), $time);
         end
         if (e.vld != 2'b00) begin
            p = e.vld[1] ? 1 : 0;
            checks++;
            if (s_mem_rdata[p] !== e.rdata) begin
               errors++;
               $display("FAIL s_mem_rdata[%0d]: got %h want %h at %0t", p, s_mem_rdata[p], e.rdata, $time);
            end
         end
      end else if (done) begin
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   end

   // Drive one cycle of requester/adapter inputs and queue what must be seen.
   task automatic cyc(input logic rst, input logic [1:0] req, input logic gnt,
                      input logic vld, input logic [31:0] rdata, input logic err,
                      input logic x_mreq, input logic [1:0] x_gnt, input logic [1:0] x_vld);
      exp_t e;
      int   gp;
      rst_i       = rst;
      s_mem_req   = req;
      m_mem_gnt   = gnt;
      m_mem_valid = vld;
      m_mem_rdata = rdata;
      m_mem_error = err;
      gp          = x_gnt[1] ? 1 : 0;
      e.req   = req;
      e.mreq  = x_mreq;
      e.gnt   = x_gnt;
      e.vld   = x_vld;
      e.addr  = s_mem_addr[gp];
      e.we    = s_mem_we[gp];
      e.wdata = s_mem_wdata[gp];
      e.be    = s_mem_be[gp];
      e.rdata = rdata;
      e.err   = err;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_i          = 1'b1;
      s_mem_req      = 2'b00;
      s_mem_we       = 2'b00;
      s_mem_addr[0]  = 32'h100;
      s_mem_addr[1]  = 32'h200;
      s_mem_wdata[0] = 32'h0;
      s_mem_wdata[1] = 32'h0;
      s_mem_be[0]    = 4'hF;
      s_mem_be[1]    = 4'hF;
      m_mem_gnt      = 1'b0;
      m_mem_valid    = 1'b0;
      m_mem_rdata    = 32'h0;
      m_mem_error    = 1'b0;
      @(posedge clk);
      #1;

      // reset: everything quiet
      cyc(1, 2'b00, 0, 0, 32'h0, 0,  0, 2'b00, 2'b00);
      cyc(1, 2'b00, 0, 0, 32'h0, 0,  0, 2'b00, 2'b00);

`ifndef MEM_ARB_FIXED_PRIO_EN
      // 1: both hold req, grants alternate 0,1,0,1; responses follow issuers
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(0, 2'b11, 1, 1, 32'hA000_0000, 0, 1, 2'b10, 2'b01);
      cyc(0, 2'b11, 1, 1, 32'hA000_0001, 1, 1, 2'b01, 2'b10);
      cyc(0, 2'b11, 1, 1, 32'hA000_0002, 0, 1, 2'b10, 2'b01);
      cyc(0, 2'b00, 1, 1, 32'hA000_0003, 0, 0, 2'b00, 2'b10);
      cyc(0, 2'b00, 0, 0, 32'h0,        0,  0, 2'b00, 2'b00);
`endif

      // 2: single write from port 1
      s_mem_addr[1]  = 32'h40;
      s_mem_we       = 2'b10;
      s_mem_wdata[1] = 32'hDEAD_BEEF;
      s_mem_be[1]    = 4'hF;
      cyc(0, 2'b10, 0, 0, 32'h0, 0,  1, 2'b00, 2'b00);
      cyc(0, 2'b10, 1, 0, 32'h0, 0,  1, 2'b10, 2'b00);
      cyc(0, 2'b00, 0, 1, 32'h0, 0,  0, 2'b00, 2'b10);
      s_mem_addr[1]  = 32'h200;
      s_mem_we       = 2'b00;
      s_mem_wdata[1] = 32'h0;

`ifndef MEM_ARB_FIXED_PRIO_EN
      // 3: stalled responses fill the FIFO; full blocks even during a pop
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b10, 2'b00);
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  0, 2'b00, 2'b00);
      cyc(0, 2'b11, 1, 1, 32'hB000_0000, 0, 0, 2'b00, 2'b01);
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(0, 2'b00, 0, 1, 32'hB000_0001, 0, 0, 2'b00, 2'b10);
      cyc(0, 2'b00, 0, 1, 32'hB000_0002, 0, 0, 2'b00, 2'b01);

      // 4: grant and response together at one entry; count stays 1, head moves
      cyc(0, 2'b01, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(0, 2'b10, 1, 1, 32'hC000_0000, 0, 1, 2'b10, 2'b01);
      cyc(0, 2'b01, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(0, 2'b01, 1, 1, 32'hC000_0001, 1, 0, 2'b00, 2'b10);
      cyc(0, 2'b00, 0, 1, 32'hC000_0002, 0, 0, 2'b00, 2'b01);

      // 5: reset with two outstanding; late valid dropped; port 0 wins next tie
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b10, 2'b00);
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(1, 2'b11, 1, 1, 32'hD000_0000, 1, 0, 2'b00, 2'b00);
      cyc(1, 2'b11, 1, 1, 32'hD000_0001, 1, 0, 2'b00, 2'b00);
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(0, 2'b00, 0, 1, 32'hD000_0002, 0, 0, 2'b00, 2'b01);
`endif

      // 6: continuous contention
`ifdef MEM_ARB_FIXED_PRIO_EN
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b01, 2'b00);
      cyc(0, 2'b11, 1, 1, 32'hE000_0000, 0, 1, 2'b01, 2'b01);
      cyc(0, 2'b11, 1, 1, 32'hE000_0001, 0, 1, 2'b01, 2'b01);
      cyc(0, 2'b00, 0, 1, 32'hE000_0002, 0, 0, 2'b00, 2'b01);
`else
      cyc(0, 2'b11, 1, 0, 32'h0,        0,  1, 2'b10, 2'b00);
      cyc(0, 2'b11, 1, 1, 32'hE000_0000, 0, 1, 2'b01, 2'b10);
      cyc(0, 2'b11, 1, 1, 32'hE000_0001, 0, 1, 2'b10, 2'b01);
      cyc(0, 2'b00, 0, 1, 32'hE000_0002, 0, 0, 2'b00, 2'b10);
`endif

      cyc(0, 2'b00, 0, 0, 32'h0, 0,  0, 2'b00, 2'b00);
      done = 1'b1;
   end

   initial begin
      #100000;
      $display("FAIL timeout: monitor did not reach summary, got no finish want finish");
      $fatal(1, "timeout");
   end

endmodule
